// File: rtl/winner_threshold_unit.sv
// Adaptive-threshold spiking stage behind a 6-input winner-take-all comparator.
// The winner spikes when it reaches its threshold, which then learns toward the input; a miss decays all thresholds.
module winner_threshold_unit #(
    parameter int P_WIDTH     = 22,
    parameter int P_TH_INIT   = 8,
    parameter int P_ETA_SHIFT = 2,
    parameter int P_DECAY     = 1,
    parameter int P_REFRACT   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [P_WIDTH-1:0] i_result,
    input  logic [6:1]         i_index,
    output logic               o_ready,
    output logic               o_spike,
    output logic [6:1]         o_spike_index,
    output logic               o_miss,
    output logic               o_err,
    output logic               o_drop,
    output logic [P_WIDTH-1:0] o_threshold
);

    localparam int CW = (P_REFRACT > 1) ? $clog2(P_REFRACT + 1) : 1;
    localparam logic [P_WIDTH-1:0] TH_INIT = P_WIDTH'(P_TH_INIT);
    localparam logic [P_WIDTH-1:0] DECAY   = P_WIDTH'(P_DECAY);
    localparam logic [CW-1:0]      REF_LD  = CW'(P_REFRACT);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_UPDATE, S_REFRACT} state_t;

    state_t             state;
    logic [P_WIDTH-1:0] res_q;
    logic [6:1]         idx_q;
    logic               spike_q;
    logic [CW-1:0]      cnt;
    logic [P_WIDTH-1:0] th [1:6];

    logic [6:1]         win_oh;
    logic [P_WIDTH-1:0] th_win;
    logic [P_WIDTH-1:0] diff;
    logic [P_WIDTH:0]   sum;
    logic [P_WIDTH-1:0] th_spike;
    logic [P_WIDTH-1:0] th_miss;

    assign o_ready = (state == S_IDLE);

    // Winner is the lowest set index bit; idx_q is stable through EVAL and UPDATE.
    always_comb begin
        win_oh = idx_q & (~idx_q + 6'd1);
        th_win = '0;
        for (int unsigned i = 1; i <= 6; i++) begin
            if (win_oh[i]) th_win = th[i];
        end
        diff     = res_q - th_win;
        sum      = {1'b0, th_win} + {1'b0, diff >> P_ETA_SHIFT};
        th_spike = sum[P_WIDTH] ? '1 : sum[P_WIDTH-1:0];
        th_miss  = (th_win >= DECAY) ? th_win - DECAY : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            res_q         <= '0;
            idx_q         <= '0;
            spike_q       <= 1'b0;
            cnt           <= '0;
            o_spike       <= 1'b0;
            o_spike_index <= '0;
            o_miss        <= 1'b0;
            o_err         <= 1'b0;
            o_drop        <= 1'b0;
            o_threshold   <= TH_INIT;
            for (int unsigned i = 1; i <= 6; i++) th[i] <= TH_INIT;
        end else begin
            o_spike       <= 1'b0;
            o_spike_index <= '0;
            o_miss        <= 1'b0;
            o_err         <= 1'b0;
            o_drop        <= i_valid && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        res_q <= i_result;
                        idx_q <= i_index;
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (idx_q == '0) begin
                        o_err <= 1'b1;
                        state <= S_IDLE;
                    end else if (res_q >= th_win && res_q != '0) begin
                        o_spike       <= 1'b1;
                        o_spike_index <= win_oh;
                        spike_q       <= 1'b1;
                        state         <= S_UPDATE;
                    end else begin
                        o_miss  <= 1'b1;
                        spike_q <= 1'b0;
                        state   <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (spike_q) begin
                        for (int unsigned i = 1; i <= 6; i++) begin
                            if (win_oh[i]) th[i] <= th_spike;
                        end
                        o_threshold <= th_spike;
                        if (P_REFRACT == 0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= REF_LD;
                            state <= S_REFRACT;
                        end
                    end else begin
                        for (int unsigned i = 1; i <= 6; i++) begin
                            th[i] <= (th[i] >= DECAY) ? th[i] - DECAY : '0;
                        end
                        o_threshold <= th_miss;
                        state       <= S_IDLE;
                    end
                end
                S_REFRACT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_winner_threshold_unit.sv
// Scoreboard bench: stimulus predicts each outcome from a threshold model, a monitor matches DUT pulses.
module tb_winner_threshold_unit;

    localparam int    W       = 22;
    localparam int    REFRACT = 4;
    localparam longint MAXV   = (longint'(1) << W) - 1;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_result = '0;
    logic [6:1]   i_index = '0;
    logic         o_ready, o_spike, o_miss, o_err, o_drop;
    logic [6:1]   o_spike_index;
    logic [W-1:0] o_threshold;

    winner_threshold_unit #(
        .P_WIDTH(W), .P_TH_INIT(8), .P_ETA_SHIFT(2), .P_DECAY(1), .P_REFRACT(REFRACT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_result(i_result),
        .i_index(i_index), .o_ready(o_ready), .o_spike(o_spike),
        .o_spike_index(o_spike_index), .o_miss(o_miss), .o_err(o_err),
        .o_drop(o_drop), .o_threshold(o_threshold)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         kind;   // 0 spike, 1 miss, 2 err
        logic [6:1] idx;
        longint     thr;
    } exp_t;

    exp_t   ev_q[$];
    int     drops_pending = 0;
    longint th[1:6];
    longint last_thr;
    int     busy;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 6; i++) th[i] = 8;
        last_thr = 8;
        busy = 0;
        ev_q.delete();
        drops_pending = 0;
    endtask

    task automatic model_accept(input longint r, input logic [6:1] idx);
        exp_t e;
        int k;
        k = 0;
        for (int i = 6; i >= 1; i--) if (idx[i]) k = i;
        e.idx = '0;
        if (k == 0) begin
            e.kind = 2;
            busy = 1;
        end else if (r >= th[k] && r != 0) begin
            th[k] = th[k] + (r - th[k]) / 4;
            if (th[k] > MAXV) th[k] = MAXV;
            last_thr = th[k];
            e.kind = 0;
            e.idx[k] = 1'b1;
            busy = 2 + REFRACT;
        end else begin
            for (int i = 1; i <= 6; i++) th[i] = (th[i] >= 1) ? th[i] - 1 : 0;
            last_thr = th[k];
            e.kind = 1;
            busy = 2;
        end
        e.thr = last_thr;
        ev_q.push_back(e);
    endtask

    // Drive one cycle at the current falling edge, then advance to the next one.
    task automatic step(input bit v, input longint r, input logic [6:1] idx);
        check("ready", longint'(o_ready), longint'(busy == 0));
        i_valid  = v;
        i_result = W'(r);
        i_index  = idx;
        if (v) begin
            if (busy == 0) model_accept(r, idx);
            else begin
                drops_pending++;
                busy--;
            end
        end else if (busy > 0) begin
            busy--;
        end
        @(negedge i_clk);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy > 0; n++) step(1'b0, 0, 6'b0);
    endtask

    initial begin : monitor
        bit     pend;
        longint pthr;
        exp_t   e;
        int     kind;
        pend = 1'b0;
        pthr = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("threshold", longint'(o_threshold), pthr);
                    pend = 1'b0;
                end
                if (o_drop) begin
                    checks++;
                    if (drops_pending > 0) drops_pending--;
                    else begin
                        errors++;
                        $display("FAIL unexpected_drop actual=1 expected=0");
                    end
                end
                if (o_spike || o_miss || o_err) begin
                    check("one_pulse", longint'(o_spike) + longint'(o_miss) + longint'(o_err), 1);
                    kind = o_spike ? 0 : (o_miss ? 1 : 2);
                    if (ev_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse actual_kind=%0d expected=none", kind);
                    end else begin
                        e = ev_q.pop_front();
                        check("kind", kind, e.kind);
                        check("spike_index", longint'(o_spike_index), longint'(e.idx));
                        pthr = e.thr;
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        repeat (3) @(negedge i_clk);
        check("rst_ready", longint'(o_ready), 1);
        check("rst_pulses", longint'({o_spike, o_miss, o_err, o_drop}), 0);
        check("rst_spike_index", longint'(o_spike_index), 0);
        check("rst_threshold", longint'(o_threshold), 8);
        i_rst_n = 1'b1;

        // Spike immediately after release, then a drop during the refractory window
        step(1'b1, 16, 6'b000001);
        repeat (3) step(1'b0, 0, 6'b0);
        step(1'b1, 99, 6'b000001);
        wait_idle();
        step(1'b1, 5, 6'b000100);
        wait_idle();
        step(1'b1, 12, 6'b001011);
        wait_idle();
        step(1'b1, 50, 6'b000000);
        wait_idle();
        // Drive every threshold to the floor, then probe zero-result and zero-threshold cases
        repeat (12) begin
            step(1'b1, 0, 6'b100000);
            wait_idle();
        end
        step(1'b1, 0, 6'b010000);
        wait_idle();
        step(1'b1, 1, 6'b010000);
        wait_idle();

        // Reset during EVAL aborts the transaction
        step(1'b1, 40, 6'b000010);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        check("midrst_threshold", longint'(o_threshold), 8);
        check("midrst_ready", longint'(o_ready), 1);
        i_rst_n = 1'b1;
        step(1'b1, 8, 6'b000010);
        wait_idle();

        for (int n = 0; n < 300; n++) begin
            bit         v;
            logic [6:1] idx;
            longint     r;
            v   = ($urandom_range(0, 9) < 6);
            idx = ($urandom_range(0, 7) == 0) ? 6'b0 : 6'($urandom_range(1, 63));
            r   = ($urandom_range(0, 3) == 0) ? (longint'($urandom) & MAXV)
                                              : longint'($urandom_range(0, 40));
            step(v, r, idx);
        end
        wait_idle();

        // Push threshold 1 toward the top of range
        repeat (60) begin
            step(1'b1, MAXV, 6'b000001);
            wait_idle();
        end
        step(1'b1, MAXV - 1, 6'b000001);
        wait_idle();

        repeat (4) step(1'b0, 0, 6'b0);
        check("pending_events", ev_q.size(), 0);
        check("pending_drops", drops_pending, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/winner_threshold_unit.md
WINNER_THRESHOLD_UNIT -- requirements
Module: winner_threshold_unit

Interface
REQ-001 SHALL have parameter P_WIDTH, default 22, the data width of the comparator result and of each threshold.
REQ-002 SHALL have parameter P_TH_INIT, default 8, the reset value of every threshold.
REQ-003 SHALL have parameter P_ETA_SHIFT, default 2, the learning-rate right-shift.
REQ-004 SHALL have parameter P_DECAY, default 1, the per-miss threshold decrement.
REQ-005 SHALL have parameter P_REFRACT, default 4, the number of refractory cycles after a spike.
REQ-006 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_valid, input, 1 bit: one-cycle strobe marking i_result/i_index as valid.
REQ-009 SHALL have port i_result, input, P_WIDTH bits: winning value from the upstream 6-input comparator.
REQ-010 SHALL have port i_index, input, [6:1]: winner flags, bit 1 = input a through bit 6 = input f.
REQ-011 SHALL have port o_ready, output, 1 bit: high when a new i_valid will be accepted.
REQ-012 SHALL have port o_spike, output, 1 bit: one-cycle output-spike pulse.
REQ-013 SHALL have port o_spike_index, output, [6:1]: one-hot index of the spiking neuron, valid only while o_spike is high.
REQ-014 SHALL have port o_miss, output, 1 bit: one-cycle pulse when the winner is below its threshold.
REQ-015 SHALL have port o_err, output, 1 bit: one-cycle pulse when i_index is all zero.
REQ-016 SHALL have port o_drop, output, 1 bit: one-cycle pulse when i_valid arrives while o_ready is low.
REQ-017 SHALL have port o_threshold, output, P_WIDTH bits: the threshold of the last evaluated neuron after update.

Function
REQ-018 SHALL hold six unsigned P_WIDTH-bit threshold registers th[1..6].
REQ-019 SHALL implement FSM states IDLE, EVAL, UPDATE, REFRACT, with o_ready = (state==IDLE).
REQ-020 IDLE: i_valid=1 SHALL register i_result and i_index and go to EVAL.
REQ-021 EVAL: SHALL select winner k as the lowest-numbered set bit of the registered index (ties, e.g. 6'b000110 gives k=2).
REQ-022 EVAL with index==0 SHALL pulse o_err on the next cycle, leave thresholds unchanged, and return to IDLE.
REQ-023 EVAL with result>=th[k] and result!=0 SHALL register o_spike=1, o_spike_index=one-hot(k), and go to UPDATE (spike path).
REQ-024 EVAL otherwise SHALL register o_miss=1 and go to UPDATE (miss path).
REQ-025 UPDATE (spike path) SHALL set th[k] <= th[k] + ((result - th[k]) >> P_ETA_SHIFT), saturating at 2^P_WIDTH-1, then go to REFRACT with the counter loaded with P_REFRACT.
REQ-026 UPDATE (miss path) SHALL set every th[i] <= max(th[i] - P_DECAY, 0) and then go to IDLE.
REQ-027 REFRACT SHALL decrement the counter each cycle and return to IDLE when it reaches 0 (exactly P_REFRACT cycles; P_REFRACT=0 returns to IDLE immediately).
REQ-028 Latency: an i_valid sampled at edge E0 SHALL produce o_spike/o_miss/o_err high for exactly one cycle, starting after edge E1.
REQ-029 o_threshold SHALL update at the UPDATE edge and otherwise hold its value.
REQ-030 i_valid while o_ready=0 SHALL be ignored, assert o_drop for one cycle, and leave state and thresholds unchanged.
REQ-031 At most one of o_spike, o_miss, o_err SHALL be high in any cycle.

Reset
REQ-032 i_rst_n low SHALL asynchronously set state=IDLE, th[1..6]=P_TH_INIT, counter=0, all pulse outputs=0, o_spike_index=0, and o_threshold=P_TH_INIT.
REQ-033 Reset asserted mid-operation (EVAL/UPDATE/REFRACT) SHALL abort the operation with no partial threshold write.
REQ-034 After reset release, the first i_valid SHALL be accepted on the first rising edge.

Verification (defaults)
REQ-035 Reset: after release o_ready=1, all pulse outputs=0, o_threshold=8.
REQ-036 Spike: i_result=16, i_index=6'b000001 SHALL give o_spike with o_spike_index=6'b000001, th[1]=10, o_threshold=10, then o_ready low for 4 cycles.
REQ-037 Miss: after REQ-036, i_result=5, i_index=6'b000100 SHALL give o_miss, th[1]=9 and all others=7.
REQ-038 Tie: i_result=12, i_index=6'b001011 SHALL pick k=1, o_spike_index=6'b000001.
REQ-039 Drop and error: i_valid during REFRACT SHALL give o_drop and no state change; i_index=0 SHALL give o_err with thresholds unchanged.
REQ-040 Saturation and floor: th=2^22-2 with i_result=2^22-1 SHALL stay at or below 2^22-1; thresholds at 0 with a miss SHALL stay 0.
